matrix_mac_sequencer: RTL and testbench
=======================================

# matrix_mac_sequencer

Sequencer and multiply-accumulate datapath for the 2x2 4-bit matrix multiplier. It sits directly downstream of the two element-selector stages, one for matrix A and one for matrix B. It drives their 3-bit `entry_out` index inputs and consumes the 4-bit elements they return. It computes C = A x B over eight cycles and presents the packed 2x2 result with a one-cycle done pulse.

## Interface
- `ELEM_W`, default 4: element width returned by the selectors.
- `RES_W`, default 9: width of one C entry (2 x 15 x 15 = 450 fits in 9 bits).
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: request a multiply; sampled only in IDLE.
- `elem_a` in 4: element from the A selector for the current `entry_out_a`.
- `elem_b` in 4: element from the B selector for the current `entry_out_b`.
- `entry_out_a` out 3: index to the A selector, registered.
- `entry_out_b` out 3: index to the B selector, registered.
- `busy` out 1: high in RUN.
- `done` out 1: single-cycle pulse; `result` is valid from this cycle onward.
- `result` out 36: {C11, C10, C01, C00}, with C00 in bits [8:0], C01 in [17:9], C10 in [26:18] and C11 in [35:27].

## Operation
- **Index encoding:** element (row r, col c) has index {r, 1'b0, c}. This gives a00=0 (bits [3:0]), a01=1 ([7:4]), a10=4 ([11:8]) and a11=5 ([15:12]). Codes 2, 3, 6 and 7 are never driven.
- **States:**
  - IDLE: `start`=1 moves to RUN with step=0.
  - RUN: step increments each cycle; step 7 moves to DONE.
  - DONE: lasts one cycle, then returns to IDLE unconditionally.
- **Step decode:** for step s (3-bit), i=s[2], j=s[1], k=s[0].
  - `entry_out_a` = {i,0,k}.
  - `entry_out_b` = {k,0,j}.
- **Accumulate:** each RUN cycle, acc <= (k==0 ? 0 : acc) + elem_a*elem_b.
  - The product is 8-bit and zero-extended. Arithmetic is unsigned and 9-bit with no overflow possible.
  - When k==1, the sum is written to internal C[i][j].
- **Result update:** `result` loads all four C entries atomically on entry to DONE. It holds the previous value during RUN and holds until the next DONE.
- **Start handling:** `start` is ignored in RUN and DONE, with no queuing. A back-to-back request must be re-asserted in IDLE.
- **Selectors:** elements are treated as combinational functions of the registered indices, valid within the same cycle.
- **Reset:** `rst` forces all of the following on the next edge, overriding any other event, including a reset arriving mid-RUN:
  - state=IDLE and step=0.
  - acc, C and `result` = 0.
  - `entry_out_a` = `entry_out_b` = 0.
  - `busy` = `done` = 0.
- **Simultaneous `rst` and `start`:** reset wins and `start` is dropped.

## Timing
- Reset values: `entry_out_a`=0, `entry_out_b`=0, `busy`=0, `done`=0, `result`=0.
- `start` is sampled at edge N. Then:
  - `busy`=1 and step 0 indices appear in cycle N+1.
  - Step 7 is in cycle N+8.
  - `done`=1 with `result` valid in cycle N+9.
  - `busy`=0 from cycle N+9.
- The earliest next `start` is sampled at edge N+10, in IDLE. Throughput is one multiply per 10 cycles.
- Indices change only on clock edges and are held constant in IDLE and DONE at their last value.
- `done` is never high for more than one consecutive cycle.

## Structure
- **Shared package `matrix_pkg`:**
  - ELEM_W and RES_W.
  - State enum {IDLE, RUN, DONE}.
  - An index function idx(r,c) = {r,1'b0,c}.
  - Result field offsets 0, 9, 18 and 27.
  - The selectors and the bench use the same package.
- **Sub-module `element_mac`:** the multiply-accumulate datapath, with inputs elem_a, elem_b, clear_acc and step_en, and output acc[RES_W-1:0].
- **`matrix_mac_sequencer`:** owns the FSM, the step counter, the index decode, the C registers and the result register.

## Test plan
- **Identity A:** A=16'h1001, B=16'h4321, `start` pulse. Required: C00=1, C01=2, C10=3, C11=4, `done` exactly at N+9.
- **Non-commutative product:** A=16'h4321, B=16'h8765. Required: C00=19, C01=22, C10=43, C11=50. Swapping A and B gives C00=23, C01=34, C10=31, C11=46.
- **Overflow bound:** A=B=16'hFFFF. Required: every 9-bit field = 450 (9'h1C2), with no wrap.
- **Index sequence:** check `entry_out_a` = 0,1,0,1,4,5,4,5 and `entry_out_b` = 0,4,1,5,0,4,1,5 over steps 0..7. Also check `result` stays unchanged during RUN.
- **Start while busy and back-to-back:** pulse `start` at N+3 and in DONE. Required: both ignored, exactly one `done`. `start` at N+10 then yields a second `done` at N+19.
- **Reset mid-RUN:** assert `rst` at step 4. Required: next cycle has `busy`=0, `result`=0 and indices=0, with no `done`. A fresh `start` afterwards gives a correct result.

Source files
------------

// File: rtl/matrix_mac_sequencer_pkg.sv
// Shared definitions for the 2x2 matrix multiplier: widths, FSM states,
// selector index encoding and packed result layout.
package matrix_pkg;

    localparam int ELEM_W   = 4;
    localparam int RES_W    = 9;
    localparam int IDX_W    = 3;
    localparam int RESULT_W = 4 * RES_W;

    localparam int C00_OFF = 0;
    localparam int C01_OFF = 9;
    localparam int C10_OFF = 18;
    localparam int C11_OFF = 27;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Element (r, c) is addressed as {r, 0, c}; the middle bit is always zero.
    function automatic logic [IDX_W-1:0] idx(input logic r, input logic c);
        return {r, 1'b0, c};
    endfunction

endpackage

// File: rtl/matrix_mac_sequencer_if.sv
// Handshake and data bundle between the sequencer and its surroundings
// (start/busy/done/result plus the A and B selector links).
interface matrix_mac_sequencer_if;
    import matrix_pkg::*;

    logic                start;
    logic [ELEM_W-1:0]   elem_a;
    logic [ELEM_W-1:0]   elem_b;
    logic [IDX_W-1:0]    entry_out_a;
    logic [IDX_W-1:0]    entry_out_b;
    logic                busy;
    logic                done;
    logic [RESULT_W-1:0] result;

    modport master (
        output start, elem_a, elem_b,
        input  entry_out_a, entry_out_b, busy, done, result
    );

    modport slave (
        input  start, elem_a, elem_b,
        output entry_out_a, entry_out_b, busy, done, result
    );

endinterface

// File: rtl/matrix_mac_sequencer_element_mac.sv
// Multiply-accumulate datapath. acc presents the running sum including the
// current product so the sequencer can capture a finished C entry on the same edge.
module element_mac #(
    parameter int ELEM_W = 4,
    parameter int RES_W  = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ELEM_W-1:0] elem_a,
    input  logic [ELEM_W-1:0] elem_b,
    input  logic              clear_acc,
    input  logic              step_en,
    output logic [RES_W-1:0]  acc
);

    logic [2*ELEM_W-1:0] prod_s;
    logic [RES_W-1:0]    base_s;
    logic [RES_W-1:0]    acc_r;

    // Unsigned product, zero-extended and added to the cleared or held partial sum
    always_comb begin
        prod_s = {{ELEM_W{1'b0}}, elem_a} * {{ELEM_W{1'b0}}, elem_b};
        if (clear_acc) begin
            base_s = {RES_W{1'b0}};
        end else begin
            base_s = acc_r;
        end
        acc = base_s + {{(RES_W - 2*ELEM_W){1'b0}}, prod_s};
    end

    // Partial-sum register, advanced only while the sequencer is stepping
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r <= {RES_W{1'b0}};
        end else if (step_en) begin
            acc_r <= acc;
        end else begin
            acc_r <= acc_r;
        end
    end

endmodule

// File: rtl/matrix_mac_sequencer.sv
// Eight-step sequencer for C = A x B on 2x2 4-bit matrices: drives selector
// indices, collects C entries and publishes the packed result with a done pulse.
module matrix_mac_sequencer
    import matrix_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    matrix_mac_sequencer_if.slave bus
);

    state_t              state_r;
    state_t              state_next_s;
    logic [IDX_W-1:0]    step_r;
    logic [IDX_W-1:0]    step_next_s;
    logic [IDX_W-1:0]    entry_a_r;
    logic [IDX_W-1:0]    entry_b_r;
    logic [IDX_W-1:0]    entry_a_next_s;
    logic [IDX_W-1:0]    entry_b_next_s;
    logic                busy_r;
    logic                done_r;
    logic [RESULT_W-1:0] result_r;
    logic [RES_W-1:0]    c_r [4];
    logic [RES_W-1:0]    acc_s;
    logic                run_s;
    logic                clear_acc_s;
    logic                pair_end_s;
    logic                last_step_s;

    // Step s = {i, j, k}: A supplies a[i][k], B supplies b[k][j]
    function automatic logic [IDX_W-1:0] a_index(input logic [IDX_W-1:0] s);
        return idx(s[2], s[0]);
    endfunction

    function automatic logic [IDX_W-1:0] b_index(input logic [IDX_W-1:0] s);
        return idx(s[0], s[1]);
    endfunction

    // Datapath control decoded from the current state and step
    always_comb begin
        run_s       = (state_r == RUN);
        clear_acc_s = ~step_r[0];
        pair_end_s  = run_s && step_r[0];
        last_step_s = run_s && (step_r == 3'd7);
    end

    // Next-state, step and index decode
    always_comb begin
        state_next_s   = state_r;
        step_next_s    = step_r;
        entry_a_next_s = entry_a_r;
        entry_b_next_s = entry_b_r;
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    state_next_s   = RUN;
                    step_next_s    = 3'd0;
                    entry_a_next_s = a_index(3'd0);
                    entry_b_next_s = b_index(3'd0);
                end else begin
                    state_next_s   = IDLE;
                end
            end
            RUN: begin
                if (step_r == 3'd7) begin
                    state_next_s   = DONE;
                end else begin
                    step_next_s    = step_r + 3'd1;
                    entry_a_next_s = a_index(step_r + 3'd1);
                    entry_b_next_s = b_index(step_r + 3'd1);
                end
            end
            DONE: begin
                state_next_s = IDLE;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // FSM, step counter and registered status/index outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            step_r    <= 3'd0;
            entry_a_r <= 3'd0;
            entry_b_r <= 3'd0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            step_r    <= step_next_s;
            entry_a_r <= entry_a_next_s;
            entry_b_r <= entry_b_next_s;
            busy_r    <= (state_next_s == RUN);
            done_r    <= (state_next_s == DONE);
        end
    end

    // C entries close on odd steps; the last one goes straight into the result
    // so all four fields update together on entry to DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int n = 0; n < 4; n++) begin
                c_r[n] <= {RES_W{1'b0}};
            end
            result_r <= {RESULT_W{1'b0}};
        end else begin
            if (pair_end_s) begin
                c_r[{step_r[2], step_r[1]}] <= acc_s;
            end
            if (last_step_s) begin
                result_r <= {acc_s, c_r[2], c_r[1], c_r[0]};
            end
        end
    end

    element_mac #(
        .ELEM_W (ELEM_W),
        .RES_W  (RES_W)
    ) u_mac (
        .clk       (clk),
        .rst       (rst),
        .elem_a    (bus.elem_a),
        .elem_b    (bus.elem_b),
        .clear_acc (clear_acc_s),
        .step_en   (run_s),
        .acc       (acc_s)
    );

    assign bus.entry_out_a = entry_a_r;
    assign bus.entry_out_b = entry_b_r;
    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.result      = result_r;

endmodule

// File: tb/tb_matrix_mac_sequencer.sv
// Self-checking bench: behavioural selectors and a matrix-product reference
// model drive directed and random multiplies through the sequencer.
module tb_matrix_mac_sequencer;
    import matrix_pkg::*;

    logic        clk;
    logic        rst;
    logic [15:0] a_mat;
    logic [15:0] b_mat;
    int          checks;
    int          failures;

    matrix_mac_sequencer_if bus ();

    matrix_mac_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Selectors: index {r,0,c} picks nibble 2*r+c of the packed matrix
    always_comb begin
        int pa;
        int pb;
        pa = 2 * int'(bus.entry_out_a[2]) + int'(bus.entry_out_a[0]);
        pb = 2 * int'(bus.entry_out_b[2]) + int'(bus.entry_out_b[0]);
        bus.elem_a = a_mat[4*pa +: 4];
        bus.elem_b = b_mat[4*pb +: 4];
    end

    function automatic logic [35:0] model_mult(input logic [15:0] a, input logic [15:0] b);
        int ea [2][2];
        int eb [2][2];
        int sum;
        logic [35:0] r;
        r = 36'd0;
        for (int row = 0; row < 2; row++) begin
            for (int col = 0; col < 2; col++) begin
                ea[row][col] = int'((a >> (4 * (2 * row + col))) & 16'hF);
                eb[row][col] = int'((b >> (4 * (2 * row + col))) & 16'hF);
            end
        end
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                sum = ea[i][0] * eb[0][j] + ea[i][1] * eb[1][j];
                r[9 * (2 * i + j) +: 9] = sum[8:0];
            end
        end
        return r;
    endfunction

    task automatic launch(input logic [15:0] a, input logic [15:0] b);
        a_mat = a;
        b_mat = b;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 1;
        while (bus.done !== 1'b1 && cyc < 30) begin
            @(negedge clk);
            cyc++;
        end
        if (bus.done !== 1'b1) cyc = -1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (bus.entry_out_a !== 3'd0) begin failures++; $display("FAIL reset_entry_a got=%0d exp=0", bus.entry_out_a); end
        checks++; if (bus.entry_out_b !== 3'd0) begin failures++; $display("FAIL reset_entry_b got=%0d exp=0", bus.entry_out_b); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus.done); end
        checks++; if (bus.result !== 36'd0) begin failures++; $display("FAIL reset_result got=%h exp=0", bus.result); end
        rst = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_start_dropped busy=%b exp=0", bus.busy); end
    endtask

    task automatic test_identity();
        int cyc;
        launch(16'h1001, 16'h4321);
        wait_done(cyc);
        checks++; if (cyc !== 9) begin failures++; $display("FAIL identity_latency got=%0d exp=9", cyc); end
        checks++; if (bus.result !== {9'd4, 9'd3, 9'd2, 9'd1}) begin failures++; $display("FAIL identity_result got=%h exp=%h", bus.result, {9'd4, 9'd3, 9'd2, 9'd1}); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL identity_busy_in_done got=%b exp=0", bus.busy); end
        @(negedge clk);
        checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL identity_done_pulse got=%b exp=0", bus.done); end
    endtask

    task automatic test_product();
        logic [15:0] av [4];
        logic [15:0] bv [4];
        logic [35:0] ev [4];
        logic [35:0] exp_r;
        int cyc;
        av[0] = 16'h4321; bv[0] = 16'h8765; ev[0] = {9'd50, 9'd43, 9'd22, 9'd19};
        av[1] = 16'h8765; bv[1] = 16'h4321; ev[1] = {9'd46, 9'd31, 9'd34, 9'd23};
        av[2] = 16'hFFFF; bv[2] = 16'hFFFF; ev[2] = {9'h1C2, 9'h1C2, 9'h1C2, 9'h1C2};
        av[3] = 16'h0000; bv[3] = 16'hFFFF; ev[3] = 36'd0;
        for (int t = 0; t < 4; t++) begin
            launch(av[t], bv[t]);
            wait_done(cyc);
            checks++; if (cyc !== 9) begin failures++; $display("FAIL directed_latency[%0d] got=%0d exp=9", t, cyc); end
            checks++; if (bus.result !== ev[t]) begin failures++; $display("FAIL directed_result[%0d] got=%h exp=%h", t, bus.result, ev[t]); end
            @(negedge clk);
        end
        for (int t = 0; t < 8; t++) begin
            av[0] = 16'($urandom);
            bv[0] = 16'($urandom);
            exp_r = model_mult(av[0], bv[0]);
            launch(av[0], bv[0]);
            wait_done(cyc);
            checks++; if (cyc !== 9) begin failures++; $display("FAIL random_latency[%0d] got=%0d exp=9", t, cyc); end
            checks++; if (bus.result !== exp_r) begin failures++; $display("FAIL random_result A=%h B=%h got=%h exp=%h", av[0], bv[0], bus.result, exp_r); end
            @(negedge clk);
        end
    endtask

    task automatic test_index_sequence();
        logic [2:0] exp_a [8];
        logic [2:0] exp_b [8];
        logic [35:0] prev;
        int errs;
        exp_a = '{3'd0, 3'd1, 3'd0, 3'd1, 3'd4, 3'd5, 3'd4, 3'd5};
        exp_b = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd0, 3'd4, 3'd1, 3'd5};
        prev = bus.result;
        launch(16'($urandom), 16'($urandom));
        for (int s = 0; s < 8; s++) begin
            checks++; if (bus.entry_out_a !== exp_a[s]) begin failures++; $display("FAIL index_a step=%0d got=%0d exp=%0d", s, bus.entry_out_a, exp_a[s]); end
            checks++; if (bus.entry_out_b !== exp_b[s]) begin failures++; $display("FAIL index_b step=%0d got=%0d exp=%0d", s, bus.entry_out_b, exp_b[s]); end
            errs = 0;
            if (bus.busy !== 1'b1) errs++;
            if (bus.done !== 1'b0) errs++;
            if (bus.result !== prev) errs++;
            checks++; if (errs != 0) begin failures++; $display("FAIL run_status step=%0d busy=%b done=%b result=%h exp_result=%h", s, bus.busy, bus.done, bus.result, prev); end
            @(negedge clk);
        end
        checks++; if (bus.done !== 1'b1) begin failures++; $display("FAIL index_done got=%b exp=1", bus.done); end
        @(negedge clk);
        checks++; if (bus.entry_out_a !== 3'd5 || bus.entry_out_b !== 3'd5) begin failures++; $display("FAIL index_hold_idle got=%0d/%0d exp=5/5", bus.entry_out_a, bus.entry_out_b); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] a1, b1, a2, b2;
        logic [35:0] exp1, exp2;
        logic exp_done;
        a1 = 16'($urandom); b1 = 16'($urandom);
        a2 = 16'($urandom); b2 = 16'($urandom);
        exp1 = model_mult(a1, b1);
        exp2 = model_mult(a2, b2);
        launch(a1, b1);
        for (int c = 1; c <= 21; c++) begin
            if (c == 10) begin
                a_mat = a2;
                b_mat = b2;
            end
            exp_done = (c == 9 || c == 19);
            checks++; if (bus.done !== exp_done) begin failures++; $display("FAIL b2b_done cycle=N+%0d got=%b exp=%b", c, bus.done, exp_done); end
            if (c == 9) begin
                checks++; if (bus.result !== exp1) begin failures++; $display("FAIL b2b_result1 got=%h exp=%h", bus.result, exp1); end
            end
            if (c == 10) begin
                checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL b2b_done_start_ignored busy=%b exp=0", bus.busy); end
            end
            if (c == 19) begin
                checks++; if (bus.result !== exp2) begin failures++; $display("FAIL b2b_result2 got=%h exp=%h", bus.result, exp2); end
            end
            bus.start = (c == 3 || c == 9 || c == 10);
            @(negedge clk);
        end
        bus.start = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        logic [15:0] a, b;
        logic [35:0] exp_r;
        int cyc;
        int bad;
        launch(16'h4321, 16'h8765);
        repeat (4) @(negedge clk);
        checks++; if (bus.entry_out_a !== 3'd4 || bus.busy !== 1'b1) begin failures++; $display("FAIL midrun_step4 entry_a=%0d busy=%b exp=4/1", bus.entry_out_a, bus.busy); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL midrun_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.result !== 36'd0) begin failures++; $display("FAIL midrun_result got=%h exp=0", bus.result); end
        checks++; if (bus.entry_out_a !== 3'd0 || bus.entry_out_b !== 3'd0) begin failures++; $display("FAIL midrun_index got=%0d/%0d exp=0/0", bus.entry_out_a, bus.entry_out_b); end
        bad = 0;
        for (int c = 0; c < 12; c++) begin
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) bad++;
            @(negedge clk);
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL midrun_quiet got=%0d active cycles exp=0", bad); end
        a = 16'($urandom); b = 16'($urandom);
        exp_r = model_mult(a, b);
        launch(a, b);
        wait_done(cyc);
        checks++; if (cyc !== 9) begin failures++; $display("FAIL after_reset_latency got=%0d exp=9", cyc); end
        checks++; if (bus.result !== exp_r) begin failures++; $display("FAIL after_reset_result got=%h exp=%h", bus.result, exp_r); end
        @(negedge clk);
    endtask

    initial begin
        clk = 1'b0;
        rst = 1'b1;
        a_mat = 16'h0000;
        b_mat = 16'h0000;
        bus.start = 1'b0;
        checks = 0;
        failures = 0;
        test_reset();
        test_identity();
        test_product();
        test_index_sequence();
        test_back_to_back();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
